// File: rtl/drive_ramp_pkg.sv
// drive_pkg: shared speed type, limits and FSM state encoding for drive_ramp.
package drive_pkg;
    typedef logic signed [11:0] spd_t;
    localparam spd_t SPD_MAX = 12'sd2047;
    localparam spd_t SPD_MIN = -12'sd2047;
    typedef enum logic [1:0] {IDLE, RAMP, STOP, HALT} ramp_state_t;
    // -2048 is folded to -2047 so downstream negation can never overflow
    function automatic spd_t clamp(spd_t v);
        return (v < SPD_MIN) ? SPD_MIN : v;
    endfunction
endpackage

// File: rtl/drive_ramp_if.sv
// drive_ramp_if: target valid/ready handshake carrying the left/right wheel speed pair.
interface drive_ramp_if;
    import drive_pkg::*;
    logic tgt_vld;
    logic tgt_rdy;
    spd_t tgt_lft;
    spd_t tgt_rght;
    modport master(output tgt_vld, tgt_lft, tgt_rght, input tgt_rdy);
    modport slave(input tgt_vld, tgt_lft, tgt_rght, output tgt_rdy);
endinterface

// File: rtl/drive_ramp_slew.sv
// slew_step: moves cur toward tgt by at most step, landing exactly on tgt without overshoot.
module slew_step
    import drive_pkg::*;
(
    input  spd_t        cur,
    input  spd_t        tgt,
    input  logic [10:0] step,
    output spd_t        nxt
);
    logic signed [12:0] diff;
    logic [12:0] mag;
    spd_t s;
    assign diff = {tgt[11], tgt} - {cur[11], cur};
    assign mag  = diff[12] ? -diff : diff;
    assign s    = {1'b0, step};
    assign nxt  = (mag <= {2'b0, step}) ? tgt : diff[12] ? cur - s : cur + s;
endmodule

// File: rtl/drive_ramp.sv
// drive_ramp: slew-rate limited wheel speed commands with a latched emergency-stop ramp to zero.
module drive_ramp
    import drive_pkg::*;
#(
    parameter int TICK_DIV   = 1024,
    parameter int STEP       = 16,
    parameter int ESTOP_STEP = 64
) (
    input  logic              clk,
    input  logic              rst,
    drive_ramp_if.slave       tgt,
    input  logic              estop,
    output spd_t              lft_spd,
    output spd_t              rght_spd,
    output logic              at_tgt
);
    localparam int CW = $clog2(TICK_DIV);
    ramp_state_t state, nxt_state;
    logic [CW-1:0] cnt;
    logic tick, acc, active;
    logic [10:0] step;
    spd_t tl, tr, cl, cr, nl, nr;
    assign tick        = cnt == CW'(TICK_DIV - 1);
    assign active      = state == IDLE || state == RAMP;
    assign tgt.tgt_rdy = !estop && active;
    assign acc         = tgt.tgt_vld && tgt.tgt_rdy;
    assign cl          = clamp(tgt.tgt_lft);
    assign cr          = clamp(tgt.tgt_rght);
    assign step        = (state == STOP) ? 11'(ESTOP_STEP) : 11'(STEP);
    slew_step u_lft (.cur(lft_spd), .tgt(tl), .step(step), .nxt(nl));
    slew_step u_rght (.cur(rght_spd), .tgt(tr), .step(step), .nxt(nr));
    // A retarget landing on the finishing tick keeps the ramp alive if it moves the goal
    always_comb begin
        nxt_state = state;
        case (state)
            IDLE:    nxt_state = estop ? STOP : (acc && (cl != lft_spd || cr != rght_spd)) ? RAMP : IDLE;
            RAMP:    nxt_state = estop ? STOP :
                                 (tick && nl == tl && nr == tr && !(acc && (cl != nl || cr != nr))) ? IDLE : RAMP;
            STOP:    nxt_state = (tick && nl == '0 && nr == '0) ? HALT : STOP;
            HALT:    nxt_state = estop ? HALT : IDLE;
            default: nxt_state = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            tl       <= '0;
            tr       <= '0;
            lft_spd  <= '0;
            rght_spd <= '0;
            at_tgt   <= 1'b1;
        end else begin
            state  <= nxt_state;
            at_tgt <= nxt_state == IDLE;
            cnt    <= tick ? '0 : cnt + 1'b1;
            if (tick && (state == RAMP || state == STOP)) begin
                lft_spd  <= nl;
                rght_spd <= nr;
            end
            if (estop && active) begin
                tl <= '0;
                tr <= '0;
            end else if (acc) begin
                tl <= cl;
                tr <= cr;
            end
        end
    end
endmodule

// File: tb/tb_drive_ramp.sv
// tb_drive_ramp: directed and random stimulus against an integer reference model of drive_ramp.
module tb_drive_ramp;
    localparam int TD = 4;
    localparam int ST = 16;
    localparam int ES = 64;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic estop = 1'b0;
    logic signed [11:0] lft_spd, rght_spd;
    logic at_tgt;
    int checks = 0;
    int errs = 0;
    int ml = 0, mr = 0, mtl = 0, mtr = 0, mcnt = 0;
    bit moving = 0, stopping = 0, halted = 0;
    drive_ramp_if ifc();
    drive_ramp #(.TICK_DIV(TD), .STEP(ST), .ESTOP_STEP(ES)) dut (
        .clk(clk), .rst(rst), .tgt(ifc.slave), .estop(estop),
        .lft_spd(lft_spd), .rght_spd(rght_spd), .at_tgt(at_tgt)
    );
    always #5 clk = ~clk;
    function automatic int clampv(int v);
        return (v < -2047) ? -2047 : v;
    endfunction
    function automatic int towards(int c, int t, int s);
        int d = t - c;
        if (d <= s && d >= -s) return t;
        return (d > 0) ? c + s : c - s;
    endfunction
    task automatic chk(string tag, int got, int exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic chk_all();
        chk("lft_spd", int'(lft_spd), ml);
        chk("rght_spd", int'(rght_spd), mr);
        chk("at_tgt", int'(at_tgt), int'(!moving && !stopping && !halted));
        chk("tgt_rdy", int'(ifc.tgt_rdy), int'(!estop && !stopping && !halted));
    endtask
    // One clock: advance the model from the inputs seen before the edge, then compare
    task automatic cyc();
        bit tick, acc, done;
        tick = (mcnt == TD - 1);
        acc = ifc.tgt_vld && !estop && !stopping && !halted;
        if (halted) halted = estop;
        else if (stopping) begin
            if (tick) begin
                ml = towards(ml, 0, ES);
                mr = towards(mr, 0, ES);
                if (ml == 0 && mr == 0) begin
                    stopping = 0;
                    halted = 1;
                end
            end
        end else begin
            if (tick && moving) begin
                ml = towards(ml, mtl, ST);
                mr = towards(mr, mtr, ST);
            end
            done = !moving || (tick && ml == mtl && mr == mtr);
            if (estop) begin
                stopping = 1;
                moving = 0;
                mtl = 0;
                mtr = 0;
            end else begin
                if (acc) begin
                    mtl = clampv(int'(ifc.tgt_lft));
                    mtr = clampv(int'(ifc.tgt_rght));
                end
                moving = done ? (acc && (ml != mtl || mr != mtr)) : 1'b1;
            end
        end
        mcnt = tick ? 0 : mcnt + 1;
        @(posedge clk);
        #1;
        chk_all();
    endtask
    task automatic send(int l, int r);
        ifc.tgt_vld = 1'b1;
        ifc.tgt_lft = 12'(l);
        ifc.tgt_rght = 12'(r);
        cyc();
        ifc.tgt_vld = 1'b0;
    endtask
    task automatic model_reset();
        ml = 0; mr = 0; mtl = 0; mtr = 0; mcnt = 0;
        moving = 0; stopping = 0; halted = 0;
    endtask
    initial begin
        ifc.tgt_vld = 1'b0;
        ifc.tgt_lft = '0;
        ifc.tgt_rght = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_lft", int'(lft_spd), 0);
        chk("rst_rght", int'(rght_spd), 0);
        chk("rst_at_tgt", int'(at_tgt), 1);
        chk("rst_rdy", int'(ifc.tgt_rdy), 1);
        rst = 1'b0;
        model_reset();
        send(100, -40);
        for (int i = 0; i < 40; i++) cyc();
        chk("ramp_lft_done", int'(lft_spd), 100);
        chk("ramp_rght_done", int'(rght_spd), -40);
        chk("ramp_at_tgt", int'(at_tgt), 1);
        send(-2048, 2047);
        for (int i = 0; i < 1200 && int'(at_tgt) == 0; i++) cyc();
        chk("clamp_lft", int'(lft_spd), -2047);
        chk("clamp_rght", int'(rght_spd), 2047);
        send(0, 0);
        for (int i = 0; i < 1200 && int'(at_tgt) == 0; i++) cyc();
        send(100, 0);
        for (int i = 0; i < 100 && int'(lft_spd) != 48; i++) cyc();
        chk("retgt_at48", int'(lft_spd), 48);
        send(0, 0);
        for (int i = 0; i < 40; i++) cyc();
        chk("retgt_lft", int'(lft_spd), 0);
        send(500, 0);
        for (int i = 0; i < 400 && int'(at_tgt) == 0; i++) cyc();
        chk("pre_estop", int'(lft_spd), 500);
        estop = 1'b1;
        #1;
        chk("estop_rdy_comb", int'(ifc.tgt_rdy), 0);
        send(300, 300);
        for (int i = 0; i < 100 && int'(lft_spd) > 200; i++) cyc();
        estop = 1'b0;
        for (int i = 0; i < 100 && !halted; i++) cyc();
        chk("stop_latched_lft", int'(lft_spd), 0);
        cyc();
        chk("halt_release_rdy", int'(ifc.tgt_rdy), 1);
        estop = 1'b1;
        for (int i = 0; i < 20; i++) cyc();
        chk("halt_hold_rdy", int'(ifc.tgt_rdy), 0);
        estop = 1'b0;
        cyc();
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 119) == 0) estop = ~estop;
            if ($urandom_range(0, 5) == 0) begin
                ifc.tgt_vld = 1'b1;
                ifc.tgt_lft = ($urandom_range(0, 7) == 0) ? 12'h800 : 12'($urandom_range(0, 4095));
                ifc.tgt_rght = 12'($urandom_range(0, 4095) >> $urandom_range(0, 8));
            end else ifc.tgt_vld = 1'b0;
            cyc();
        end
        ifc.tgt_vld = 1'b0;
        estop = 1'b0;
        for (int i = 0; i < 400 && (stopping || halted); i++) cyc();
        send(0, 0);
        for (int i = 0; i < 1200 && int'(at_tgt) == 0; i++) cyc();
        send(100, 0);
        for (int i = 0; i < 100 && int'(lft_spd) != 48; i++) cyc();
        chk("arst_at48", int'(lft_spd), 48);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_lft", int'(lft_spd), 0);
        chk("arst_at_tgt", int'(at_tgt), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        send(-40, 20);
        for (int i = 0; i < 20; i++) cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end
endmodule
